// File: rtl/ddr3_rx_dly_trainer.sv
// Per-lane read-capture delay trainer. Sweeps the IOD RX delay line upward
// from its loaded value and scores each tap with the eye-monitor flags and a
// known training pattern. It then parks the line at the centre of the first
// passing window.
module ddr3_rx_dly_trainer #(
  parameter int unsigned MAX_TAP     = 127,
  parameter int unsigned SETTLE_CYC  = 8,
  parameter int unsigned SAMPLE_CYC  = 16,
  parameter logic [3:0]  EXP_PATTERN = 4'b0101
) (
  input  logic       FAB_CLK,
  input  logic       ARST_N,
  input  logic       train_start,
  output logic       train_busy,
  output logic       train_done,
  output logic       train_fail,
  output logic [7:0] tap_pos,
  output logic [7:0] win_first,
  output logic [7:0] win_last,
  input  logic [3:0] RX_DATA_0,
  input  logic       EYE_MONITOR_EARLY_0,
  input  logic       EYE_MONITOR_LATE_0,
  input  logic       DELAY_LINE_OUT_OF_RANGE_0,
  output logic       EYE_MONITOR_CLEAR_FLAGS_0,
  output logic       DELAY_LINE_MOVE_0,
  output logic       DELAY_LINE_DIRECTION_0,
  output logic       DELAY_LINE_LOAD_0
);

  typedef enum logic [3:0] {
    StIdle,
    StLoad,
    StSettle,
    StClear,
    StSample,
    StScore,
    StStepUp,
    StCentre,
    StCentreMove,
    StDone,
    StFail
  } state_e;

  state_e     state;
  logic [7:0] cnt;
  logic       found;     // a passing tap has been seen in this sweep
  logic       centring;  // SETTLE returns to CENTRE instead of CLEAR
  logic       pass_acc;  // AND of per-cycle sample results at this tap

  logic [8:0] win_sum;
  logic [7:0] target;
  logic       sample_ok;
  logic       at_end;

  // Centre rounds toward win_first; 9-bit sum avoids overflow on high taps.
  assign win_sum   = {1'b0, win_first} + {1'b0, win_last};
  assign target    = win_sum[8:1];
  assign sample_ok = !EYE_MONITOR_EARLY_0 && !EYE_MONITOR_LATE_0 && (RX_DATA_0 == EXP_PATTERN);
  assign at_end    = (tap_pos == 8'(MAX_TAP)) || DELAY_LINE_OUT_OF_RANGE_0;

  // Training FSM with all outputs registered; pulses default low every cycle.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state                     <= StIdle;
      cnt                       <= 8'd0;
      found                     <= 1'b0;
      centring                  <= 1'b0;
      pass_acc                  <= 1'b0;
      tap_pos                   <= 8'd0;
      win_first                 <= 8'd0;
      win_last                  <= 8'd0;
      train_busy                <= 1'b0;
      train_done                <= 1'b0;
      train_fail                <= 1'b0;
      EYE_MONITOR_CLEAR_FLAGS_0 <= 1'b0;
      DELAY_LINE_MOVE_0         <= 1'b0;
      DELAY_LINE_DIRECTION_0    <= 1'b0;
      DELAY_LINE_LOAD_0         <= 1'b0;
    end else begin
      train_done                <= 1'b0;
      train_fail                <= 1'b0;
      EYE_MONITOR_CLEAR_FLAGS_0 <= 1'b0;
      DELAY_LINE_MOVE_0         <= 1'b0;
      DELAY_LINE_LOAD_0         <= 1'b0;

      unique case (state)
        StIdle: begin
          if (train_start) begin
            state                  <= StLoad;
            train_busy             <= 1'b1;
            DELAY_LINE_LOAD_0      <= 1'b1;
            DELAY_LINE_DIRECTION_0 <= 1'b1;
            tap_pos                <= 8'd0;
            found                  <= 1'b0;
            centring               <= 1'b0;
          end
        end

        StLoad: begin
          state <= StSettle;
          cnt   <= 8'd0;
        end

        StSettle: begin
          if (cnt == 8'(SETTLE_CYC - 1)) begin
            if (centring) begin
              state <= StCentre;
            end else begin
              state                     <= StClear;
              EYE_MONITOR_CLEAR_FLAGS_0 <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        StClear: begin
          state    <= StSample;
          cnt      <= 8'd0;
          pass_acc <= 1'b1;
        end

        StSample: begin
          pass_acc <= pass_acc & sample_ok;
          if (cnt == 8'(SAMPLE_CYC - 1)) begin
            state <= StScore;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        StScore: begin
          if (pass_acc && !found) begin
            win_first <= tap_pos;
            win_last  <= tap_pos;
            found     <= 1'b1;
          end else if (pass_acc) begin
            win_last <= tap_pos;
          end

          if ((!pass_acc && found) || (at_end && (found || pass_acc))) begin
            // Direction drops here so it is stable for a full cycle before any MOVE.
            state                  <= StCentre;
            centring               <= 1'b1;
            DELAY_LINE_DIRECTION_0 <= 1'b0;
          end else if (at_end) begin
            state                  <= StFail;
            train_fail             <= 1'b1;
            DELAY_LINE_LOAD_0      <= 1'b1;
            DELAY_LINE_DIRECTION_0 <= 1'b0;
            tap_pos                <= 8'd0;
          end else begin
            state             <= StStepUp;
            DELAY_LINE_MOVE_0 <= 1'b1;
            tap_pos           <= tap_pos + 8'd1;
          end
        end

        StStepUp: begin
          state <= StSettle;
          cnt   <= 8'd0;
        end

        StCentre: begin
          if (tap_pos > target) begin
            state             <= StCentreMove;
            DELAY_LINE_MOVE_0 <= 1'b1;
            tap_pos           <= tap_pos - 8'd1;
          end else begin
            state      <= StDone;
            train_done <= 1'b1;
          end
        end

        StCentreMove: begin
          state <= StSettle;
          cnt   <= 8'd0;
        end

        StDone: begin
          state      <= StIdle;
          train_busy <= 1'b0;
        end

        StFail: begin
          state      <= StIdle;
          train_busy <= 1'b0;
        end

        default: begin
          state      <= StIdle;
          train_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_rx_dly_trainer.sv
// Self-checking bench for ddr3_rx_dly_trainer: a behavioural lane (delay line,
// sticky eye flags, training data) plus a sweep-result model and per-cycle
// protocol checks.
module tb_ddr3_rx_dly_trainer;

  localparam int MaxTap = 127;
  localparam int Settle = 8;

  logic       FAB_CLK = 1'b0;
  logic       ARST_N  = 1'b1;
  logic       train_start = 1'b0;
  logic       train_busy, train_done, train_fail;
  logic [7:0] tap_pos, win_first, win_last;
  logic [3:0] RX_DATA_0 = 4'b0101;
  logic       EYE_MONITOR_EARLY_0 = 1'b0;
  logic       EYE_MONITOR_LATE_0  = 1'b0;
  logic       DELAY_LINE_OUT_OF_RANGE_0;
  logic       EYE_MONITOR_CLEAR_FLAGS_0, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0;
  logic       DELAY_LINE_LOAD_0;

  ddr3_rx_dly_trainer dut (
    .FAB_CLK                   (FAB_CLK),
    .ARST_N                    (ARST_N),
    .train_start               (train_start),
    .train_busy                (train_busy),
    .train_done                (train_done),
    .train_fail                (train_fail),
    .tap_pos                   (tap_pos),
    .win_first                 (win_first),
    .win_last                  (win_last),
    .RX_DATA_0                 (RX_DATA_0),
    .EYE_MONITOR_EARLY_0       (EYE_MONITOR_EARLY_0),
    .EYE_MONITOR_LATE_0        (EYE_MONITOR_LATE_0),
    .DELAY_LINE_OUT_OF_RANGE_0 (DELAY_LINE_OUT_OF_RANGE_0),
    .EYE_MONITOR_CLEAR_FLAGS_0 (EYE_MONITOR_CLEAR_FLAGS_0),
    .DELAY_LINE_MOVE_0         (DELAY_LINE_MOVE_0),
    .DELAY_LINE_DIRECTION_0    (DELAY_LINE_DIRECTION_0),
    .DELAY_LINE_LOAD_0         (DELAY_LINE_LOAD_0)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Lane configuration: passing eye [cfg_lo, cfg_hi], end stop at cfg_oor,
  // one-cycle data glitch at cfg_gl, cfg_dmode = failing taps show bad data.
  int cfg_lo = 0, cfg_hi = 0, cfg_oor = 1000, cfg_gl = -1, cfg_dmode = 0;

  // Lane / observer state, written only by the compare process.
  int phys = 0, since_clr = 0, since_ml = 1000;
  int up_cnt = 0, dn_cnt = 0, done_cnt = 0, fail_cnt = 0, clr_cnt = 0;
  int done_tap = 0, done_first = 0, done_last = 0, fail_tap = 0, fail_load = 0;
  logic prev_move = 1'b0, prev_dir = 1'b0;

  assign DELAY_LINE_OUT_OF_RANGE_0 = (phys >= cfg_oor);

  // Compare process and lane model, evaluated on the falling edge.
  initial begin
    forever begin
      @(negedge FAB_CLK);
      if (DELAY_LINE_LOAD_0) phys = 0;
      else if (DELAY_LINE_MOVE_0) phys = DELAY_LINE_DIRECTION_0 ? phys + 1 : phys - 1;

      if (ARST_N && train_busy) chk("tap_track", int'(tap_pos), phys);
      if (ARST_N && DELAY_LINE_MOVE_0) begin
        chk("move_back_to_back", int'(prev_move), 0);
        chk("dir_stable_before_move", int'(DELAY_LINE_DIRECTION_0), int'(prev_dir));
        chk("settle_before_move", int'(since_ml >= Settle), 1);
        if (DELAY_LINE_DIRECTION_0) up_cnt++;
        else dn_cnt++;
      end
      if (ARST_N && EYE_MONITOR_CLEAR_FLAGS_0) begin
        chk("settle_before_clear", int'(since_ml >= Settle), 1);
        clr_cnt++;
      end
      if (train_done) begin
        done_cnt++;
        done_tap   = tap_pos;
        done_first = win_first;
        done_last  = win_last;
      end
      if (train_fail) begin
        fail_cnt++;
        fail_tap  = tap_pos;
        fail_load = DELAY_LINE_LOAD_0;
      end

      if (!ARST_N) since_ml = 1000;
      else if (DELAY_LINE_MOVE_0 || DELAY_LINE_LOAD_0) since_ml = 0;
      else since_ml++;

      if (EYE_MONITOR_CLEAR_FLAGS_0) begin
        EYE_MONITOR_EARLY_0 = 1'b0;
        EYE_MONITOR_LATE_0  = 1'b0;
        since_clr = 0;
      end else begin
        since_clr++;
        if (cfg_dmode == 0) begin
          if (phys < cfg_lo) EYE_MONITOR_EARLY_0 = 1'b1;
          if (phys > cfg_hi) EYE_MONITOR_LATE_0 = 1'b1;
        end
      end
      RX_DATA_0 = 4'b0101;
      if (cfg_dmode != 0 && (phys < cfg_lo || phys > cfg_hi)) RX_DATA_0 = 4'b1010;
      if (phys == cfg_gl && since_clr == 5) RX_DATA_0 = 4'b0000;
      prev_move = DELAY_LINE_MOVE_0;
      prev_dir  = DELAY_LINE_DIRECTION_0;
    end
  end

  // Sweep outcome from the eye description alone.
  task automatic model(input int lo, input int hi, input int oor, input int gl,
                       output int ok, output int first, output int last,
                       output int stop, output int centre);
    int p;
    ok = 0; first = 0; last = 0; stop = 0;
    for (int t = 0; t <= MaxTap; t++) begin
      p = (t >= lo && t <= hi && t != gl) ? 1 : 0;
      stop = t;
      if (p != 0 && ok == 0) begin
        first = t; last = t; ok = 1;
      end else if (p != 0) begin
        last = t;
      end else if (ok != 0) begin
        break;
      end
      if (t >= oor) break;
    end
    centre = (first + last) / 2;
  endtask

  task automatic run_case(input string nm, input int lo, input int hi, input int oor,
                          input int gl, input int dmode, input int l_ok, input int l_first,
                          input int l_last, input int l_centre, input int l_up, input int l_dn,
                          input int extra_start, input int start_at_end);
    int m_ok, m_first, m_last, m_stop, m_centre;
    int up0, dn0, d0, f0, cyc;
    model(lo, hi, oor, gl, m_ok, m_first, m_last, m_stop, m_centre);
    chk({nm, "_model_ok"}, m_ok, l_ok);
    chk({nm, "_model_up"}, m_stop, l_up);
    chk({nm, "_model_dn"}, m_ok != 0 ? m_stop - m_centre : 0, l_dn);
    if (l_ok != 0) begin
      chk({nm, "_model_first"}, m_first, l_first);
      chk({nm, "_model_last"}, m_last, l_last);
      chk({nm, "_model_centre"}, m_centre, l_centre);
    end

    cfg_lo = lo; cfg_hi = hi; cfg_oor = oor; cfg_gl = gl; cfg_dmode = dmode;
    up0 = up_cnt; dn0 = dn_cnt; d0 = done_cnt; f0 = fail_cnt;
    @(negedge FAB_CLK); #1;
    train_start = 1'b1;
    @(negedge FAB_CLK); #1;
    train_start = 1'b0;
    chk({nm, "_load_after_start"}, int'(DELAY_LINE_LOAD_0), 1);
    chk({nm, "_busy_after_start"}, int'(train_busy), 1);

    cyc = 0;
    while (done_cnt == d0 && fail_cnt == f0 && cyc < 20000) begin
      train_start = (extra_start != 0 && cyc == extra_start) ? 1'b1 : 1'b0;
      @(negedge FAB_CLK); #1;
      cyc++;
    end
    train_start = 1'b0;
    chk({nm, "_finished"}, (done_cnt - d0) + (fail_cnt - f0), 1);
    chk({nm, "_up_moves"}, up_cnt - up0, m_stop);
    chk({nm, "_down_moves"}, dn_cnt - dn0, m_ok != 0 ? m_stop - m_centre : 0);
    if (m_ok != 0) begin
      chk({nm, "_done_pulse"}, done_cnt - d0, 1);
      chk({nm, "_tap"}, done_tap, m_centre);
      chk({nm, "_win_first"}, done_first, m_first);
      chk({nm, "_win_last"}, done_last, m_last);
    end else begin
      chk({nm, "_fail_pulse"}, fail_cnt - f0, 1);
      chk({nm, "_fail_tap"}, fail_tap, 0);
      chk({nm, "_fail_with_load"}, fail_load, 1);
    end

    // Optionally collide a start with the DONE/FAIL cycle; it must be dropped.
    if (start_at_end != 0) train_start = 1'b1;
    @(negedge FAB_CLK); #1;
    train_start = 1'b0;
    chk({nm, "_busy_low_after"}, int'(train_busy), 0);
    chk({nm, "_no_load_after"}, int'(DELAY_LINE_LOAD_0), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge FAB_CLK); #1;
      chk({nm, "_stays_idle"}, int'(train_busy), 0);
    end
    chk({nm, "_tap_held"}, int'(tap_pos), m_ok != 0 ? m_centre : 0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, int'(train_busy), 0);
    chk({nm, "_done"}, int'(train_done), 0);
    chk({nm, "_fail"}, int'(train_fail), 0);
    chk({nm, "_tap_pos"}, int'(tap_pos), 0);
    chk({nm, "_win_first"}, int'(win_first), 0);
    chk({nm, "_win_last"}, int'(win_last), 0);
    chk({nm, "_clear"}, int'(EYE_MONITOR_CLEAR_FLAGS_0), 0);
    chk({nm, "_move"}, int'(DELAY_LINE_MOVE_0), 0);
    chk({nm, "_dir"}, int'(DELAY_LINE_DIRECTION_0), 0);
    chk({nm, "_load"}, int'(DELAY_LINE_LOAD_0), 0);
  endtask

  initial begin
    int c0, cyc;
    #1 ARST_N = 1'b0;
    #3;
    chk_all_zero("reset");
    repeat (3) @(negedge FAB_CLK);
    #1 ARST_N = 1'b1;
    repeat (2) @(negedge FAB_CLK);

    //       name      lo   hi   oor   gl  dm ok  fst lst cen  up  dn  extra end
    run_case("eye10_30", 10, 30, 1000, -1, 0, 1, 10, 30, 20,  31, 11, 0,    1);
    run_case("no_pass",  200, 200, 1000, -1, 1, 0, 0, 0,  0,  127, 0, 0,    1);
    run_case("oor60",    40, 127, 60,  -1, 0, 1, 40, 60, 50,  60, 10, 0,    0);
    run_case("tap0",     0,  0,  1000, -1, 0, 1, 0,  0,  0,   1,  1,  0,    0);
    run_case("glitch25", 10, 30, 1000, 25, 0, 1, 10, 24, 17,  25, 8,  0,    0);
    run_case("tap0_oor", 0,  0,  0,    -1, 0, 1, 0,  0,  0,   0,  0,  0,    0);
    run_case("all_pass", 0, 127, 1000, -1, 0, 1, 0, 127, 63, 127, 64, 0,    0);

    // Asynchronous reset during SAMPLE at tap 2, then a clean restart.
    cfg_lo = 10; cfg_hi = 30; cfg_oor = 1000; cfg_gl = -1; cfg_dmode = 0;
    c0 = clr_cnt;
    @(negedge FAB_CLK); #1 train_start = 1'b1;
    @(negedge FAB_CLK); #1 train_start = 1'b0;
    cyc = 0;
    while (clr_cnt - c0 < 3 && cyc < 2000) begin
      @(negedge FAB_CLK); #1;
      cyc++;
    end
    chk("rst_reached_tap2", int'(tap_pos), 2);
    repeat (5) @(negedge FAB_CLK);
    #2 ARST_N = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    repeat (2) @(negedge FAB_CLK);
    #1 ARST_N = 1'b1;
    @(negedge FAB_CLK); #1;
    chk("post_reset_idle", int'(train_busy), 0);
    run_case("restart", 10, 30, 1000, -1, 0, 1, 10, 30, 20, 31, 11, 300, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
